decoder_arbiter: RTL and testbench

DECODER_ARBITER -- requirements
Module: decoder_arbiter

---
 rtl/decoder_arbiter_pkg.sv | 27 ++
 rtl/decoder_arbiter_decoder4_16.sv | 11 +
 rtl/decoder_arbiter.sv | 132 +++++++++++++
 tb/tb_decoder_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/decoder_arbiter_pkg.sv
// Shared types and constants for the decoder arbiter: FSM state encoding,
// decoder widths and a constant-foldable clog2 helper.
package decoder_arbiter_pkg;

    localparam int ADDR_W   = 4;
    localparam int ONEHOT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/decoder_arbiter_decoder4_16.sv
// Plain combinational 4-to-16 one-hot decoder shared by all requesters.
module decoder4_16
    import decoder_arbiter_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    output logic [ONEHOT_W-1:0] onehot
);

    assign onehot = ONEHOT_W'(1) << addr;

endmodule

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to one shared
// 4-to-16 decoder. Each accepted request walks IDLE -> DECODE -> RESP and
// the result is held until the consumer takes it.
module decoder_arbiter
    import decoder_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [ADDR_W*N_REQ-1:0]   req_addr,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ONEHOT_W-1:0]       rsp_onehot,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    localparam logic [ID_W:0]   N_REQ_EXT = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(N_REQ - 1);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ONEHOT_W-1:0]   rsp_onehot_q, rsp_onehot_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  busy_q, busy_d;

    logic [2*N_REQ-1:0]    valid_dbl;
    logic [N_REQ-1:0]      valid_rot;
    logic [ID_W-1:0]       win_off;
    logic [ID_W:0]         win_sum;
    logic [ID_W-1:0]       win_idx;
    logic [ID_W-1:0]       win_next;
    logic                  any_valid;
    logic [ONEHOT_W-1:0]   dec_onehot;

    // Rotate the request vector so rr_ptr lands at bit 0.
    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = valid_dbl[rr_ptr_q +: N_REQ];
    assign any_valid = |req_valid;

    // Priority pick of the lowest set bit in the rotated vector.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        win_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                win_off = ID_W'(i);
            end
        end
    end

    // Rotate the winning offset back to an absolute requester index.
    assign win_sum  = {1'b0, win_off} + {1'b0, rr_ptr_q};
    assign win_idx  = (win_sum >= N_REQ_EXT) ? ID_W'(win_sum - N_REQ_EXT)
                                             : win_sum[ID_W-1:0];
    assign win_next = (win_idx == LAST_IDX) ? '0 : win_idx + ID_W'(1);

    decoder4_16 u_decoder (
        .addr   (addr_q),
        .onehot (dec_onehot)
    );

    // Next-state and datapath update for the three-state transaction FSM.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        addr_d       = addr_q;
        rsp_onehot_d = rsp_onehot_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    addr_d   = req_addr[win_idx*ADDR_W +: ADDR_W];
                    rsp_id_d = win_idx;
                    rr_ptr_d = win_next;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                rsp_onehot_d = dec_onehot;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_onehot_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State register; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            addr_q       <= '0;
            rsp_onehot_q <= '0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            addr_q       <= addr_d;
            rsp_onehot_q <= rsp_onehot_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Accept strobe is combinational so the winner sees it in the same cycle.
    assign req_ready  = (state_q == IDLE && any_valid) ? (N_REQ'(1) << win_idx) : '0;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_onehot = rsp_onehot_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
// Directed bench for decoder_arbiter: reset, single transaction, fairness,
// backpressure, pointer wrap, reset mid-transaction and all 16 addresses.
module tb_decoder_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_addr;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_onehot;
    logic [1:0]  rsp_id;
    logic        busy;

    int vectors;
    int miscompares;

    decoder_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_onehot (rsp_onehot),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready high: grant, decode, response, consume.
    task automatic xact(input logic [3:0] v, input int exp_id, input logic [15:0] exp_oh);
        logic [3:0] exp_ready;
        exp_ready = 4'b0001 << exp_id;
        req_valid = v;
        rsp_ready = 1'b1;
        #1;
        check("grant", 16'(req_ready), 16'(exp_ready));
        tick();
        tick();
        check("rsp_valid", 16'(rsp_valid), 16'd1);
        check("rsp_onehot", rsp_onehot, exp_oh);
        check("rsp_id", 16'(rsp_id), 16'(exp_id));
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] one16;
        vectors     = 0;
        miscompares = 0;
        one16       = 16'd1;
        rst         = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        rsp_ready   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_onehot", rsp_onehot, 16'h0000);
        check("rst_id", 16'(rsp_id), 16'd0);
        check("rst_ready", 16'(req_ready), 16'd0);
        rst = 1'b0;
        tick();

        // Single request from requester 0, address 0xA
        req_addr  = 16'h000A;
        req_valid = 4'b0001;
        #1;
        check("single_ready", 16'(req_ready), 16'h0001);
        tick();
        req_valid = '0;
        #1;
        check("single_decode_busy", 16'(busy), 16'd1);
        check("single_decode_valid", 16'(rsp_valid), 16'd0);
        check("single_decode_ready", 16'(req_ready), 16'd0);
        tick();
        check("single_valid", 16'(rsp_valid), 16'd1);
        check("single_onehot", rsp_onehot, 16'h0400);
        check("single_id", 16'(rsp_id), 16'd0);
        rsp_ready = 1'b1;
        tick();
        check("single_done_valid", 16'(rsp_valid), 16'd0);
        check("single_done_onehot", rsp_onehot, 16'h0000);
        check("single_done_busy", 16'(busy), 16'd0);

        // Fairness: all requesting, addr k = k+3
        do_reset();
        req_addr = 16'h6543;
        xact(4'b1111, 0, 16'h0008);
        xact(4'b1111, 1, 16'h0010);
        xact(4'b1111, 2, 16'h0020);
        xact(4'b1111, 3, 16'h0040);
        xact(4'b1111, 0, 16'h0008);

        // Backpressure: requester 1 wins, result held for 5 cycles
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("bp_grant", 16'(req_ready), 16'h0002);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 16'(rsp_valid), 16'd1);
            check("bp_onehot", rsp_onehot, 16'h0010);
            check("bp_id", 16'(rsp_id), 16'd1);
            check("bp_ready", 16'(req_ready), 16'd0);
            check("bp_busy", 16'(busy), 16'd1);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        check("bp_release", 16'(rsp_valid), 16'd0);

        // Wrap: pointer now 2; grant 2 moves it to 3, then 0101 -> 0, then 2
        xact(4'b0100, 2, 16'h0020);
        xact(4'b0101, 0, 16'h0008);
        xact(4'b0101, 2, 16'h0020);
        req_valid = '0;

        // Reset while in DECODE discards the result
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        rst       = 1'b1;
        #1;
        check("rstmid_valid", 16'(rsp_valid), 16'd0);
        check("rstmid_busy", 16'(busy), 16'd0);
        tick();
        check("rstmid_valid2", 16'(rsp_valid), 16'd0);
        rst = 1'b0;
        tick();
        check("rstmid_valid3", 16'(rsp_valid), 16'd0);
        xact(4'b1010, 1, 16'h0010);

        // Exhaustive addresses through requester 2
        for (int a = 0; a < 16; a++) begin
            req_addr = {4'h6, 4'(a), 4'h4, 4'h3};
            xact(4'b0100, 2, one16 << a);
        end
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
